pipelined_segmented_adder: RTL and testbench

Parametrised successor to the fixed 8-bit ripple adder used in the convolution datapath. It adds or subtracts two WIDTH-bit operands with carry-in. The carry chain is split into SEG_WIDTH-bit segments, with one pipeline register per segment, so a long chain never sits in one cycle. It accepts one operation per cycle under a valid/ready handshake in both directions. It sits between the partial-product generator and the accumulator of the convolution multiplier.

---
 rtl/pipelined_segmented_adder.sv | 158 +++++++++++++++
 tb/tb_pipelined_segmented_adder.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_segmented_adder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pipelined_segmented_adder
// Description : WIDTH-bit add/subtract with carry-in. The carry chain is cut
//               into SEG_WIDTH-bit segments, and each segment is resolved in
//               its own pipeline stage (NSEG = WIDTH/SEG_WIDTH stages). The
//               upper operand bits are skewed in and the lower sum bits are
//               de-skewed out through the same stage registers. A global
//               stall drives valid/ready flow control on both sides.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   rising-edge clock for all state
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   a/b/cin/sub carry an operation this cycle
//   in_ready   out  operation is accepted this cycle (combinational)
//   a, b       in   WIDTH-bit operands
//   cin        in   carry-in, ignored when sub=1
//   sub        in   0: a+b+cin   1: a-b (a + ~b + 1)
//   out_valid  out  sum/cout/ovf hold a result
//   out_ready  in   downstream takes the result this cycle
//   sum        out  result modulo 2^WIDTH
//   cout       out  carry out of the MSB (1 = no borrow when subtracting)
//   ovf        out  two's-complement overflow
// ============================================================================
module pipelined_segmented_adder #(
  parameter int WIDTH     = 16,
  parameter int SEG_WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSEG = WIDTH / SEG_WIDTH;

  generate
    if ((SEG_WIDTH < 1) || (WIDTH < SEG_WIDTH) || ((WIDTH % SEG_WIDTH) != 0)) begin : g_param_check
      $error("pipelined_segmented_adder: WIDTH must be a non-zero multiple of SEG_WIDTH");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Entry conditioning and flow control
  // --------------------------------------------------------------------------
  logic             w_advance;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_c0;

  // Subtraction is a + ~b + 1, so the carry-in is forced high in that mode.
  assign w_b_eff   = sub ? ~b : b;
  assign w_c0      = sub | cin;

  // Whole-pipeline stall: everything moves only when the output slot is free
  // or being emptied this cycle. Bubbles are never squeezed out.
  assign w_advance = out_ready | ~out_valid;
  assign in_ready  = w_advance;

  // --------------------------------------------------------------------------
  // Stage registers
  //   r_a/r_b : operands carried forward; stage k+1 consumes segment k+1
  //   r_s     : sum bits resolved so far (segments 0..k of stage k)
  //   r_c     : carry out of the segment resolved in stage k
  // --------------------------------------------------------------------------
  logic             r_vld [NSEG];
  logic [WIDTH-1:0] r_a   [NSEG];
  logic [WIDTH-1:0] r_b   [NSEG];
  logic [WIDTH-1:0] r_s   [NSEG];
  logic             r_c   [NSEG];
  logic             r_cmsb;

  // Per-stage inputs (from the entry port for stage 0, else the predecessor)
  logic             w_vld_in   [NSEG];
  logic [WIDTH-1:0] w_a_in     [NSEG];
  logic [WIDTH-1:0] w_b_in     [NSEG];
  logic [WIDTH-1:0] w_s_in     [NSEG];
  logic             w_c_in     [NSEG];
  logic [SEG_WIDTH:0] w_seg_sum [NSEG];
  logic [WIDTH-1:0] w_s_next   [NSEG];
  logic             w_cmsb;

  genvar k;
  generate
    for (k = 0; k < NSEG; k++) begin : g_stage
      if (k == 0) begin : g_first
        assign w_vld_in[k] = in_valid;
        assign w_a_in[k]   = a;
        assign w_b_in[k]   = w_b_eff;
        assign w_s_in[k]   = '0;
        assign w_c_in[k]   = w_c0;
      end else begin : g_rest
        assign w_vld_in[k] = r_vld[k-1];
        assign w_a_in[k]   = r_a[k-1];
        assign w_b_in[k]   = r_b[k-1];
        assign w_s_in[k]   = r_s[k-1];
        assign w_c_in[k]   = r_c[k-1];
      end

      // One SEG_WIDTH-bit ripple segment; the extra MSB is the segment carry.
      assign w_seg_sum[k] = {1'b0, w_a_in[k][k*SEG_WIDTH +: SEG_WIDTH]}
                          + {1'b0, w_b_in[k][k*SEG_WIDTH +: SEG_WIDTH]}
                          + {{SEG_WIDTH{1'b0}}, w_c_in[k]};

      // Segment k of the incoming partial sum is still zero, so OR-ing the new
      // segment in is the same as overwriting that slice.
      assign w_s_next[k] = w_s_in[k]
                         | (WIDTH'(w_seg_sum[k][SEG_WIDTH-1:0]) << (k*SEG_WIDTH));
    end
  endgenerate

  // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ c_in.
  assign w_cmsb = w_a_in[NSEG-1][WIDTH-1]
                ^ w_b_in[NSEG-1][WIDTH-1]
                ^ w_seg_sum[NSEG-1][SEG_WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSEG; i++) begin
        r_vld[i] <= 1'b0;
        r_a[i]   <= '0;
        r_b[i]   <= '0;
        r_s[i]   <= '0;
        r_c[i]   <= 1'b0;
      end
      r_cmsb <= 1'b0;
    end else if (w_advance) begin
      for (int i = 0; i < NSEG; i++) begin
        r_vld[i] <= w_vld_in[i];
        r_a[i]   <= w_a_in[i];
        r_b[i]   <= w_b_in[i];
        r_s[i]   <= w_s_next[i];
        r_c[i]   <= w_seg_sum[i][SEG_WIDTH];
      end
      r_cmsb <= w_cmsb;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs straight from the last stage
  // --------------------------------------------------------------------------
  assign out_valid = r_vld[NSEG-1];
  assign sum       = r_s[NSEG-1];
  assign cout      = r_c[NSEG-1];
  assign ovf       = r_cmsb ^ r_c[NSEG-1];

endmodule
`default_nettype wire

// File: tb/tb_pipelined_segmented_adder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_segmented_adder
// Description : Scoreboard bench. Drivers push expected results into queues
//               when an operation is accepted; negedge monitors pop and
//               compare whenever a result is transferred out. The 16/4 DUT
//               gets directed vectors, streaming with backpressure and a
//               mid-flight reset; three further widths run random traffic
//               against a flat-adder model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_segmented_adder;

  localparam int W    = 16;
  localparam int NSEG = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         rst_sw_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int cyc     = 0;
  int n_tests = 0;
  int n_fail  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  pipelined_segmented_adder #(.WIDTH(16), .SEG_WIDTH(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Scoreboard for the main DUT
  // --------------------------------------------------------------------------
  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           acc;
    bit           lat;
  } exp_t;

  exp_t exp_q[$];

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 64'(sum), 64'(0));
        check("unexpected_output_valid", 64'(out_valid), 64'(0));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sum", 64'(sum), 64'(e.sum));
        check("cout", 64'(cout), 64'(e.cout));
        check("ovf", 64'(ovf), 64'(e.ovf));
        if (e.lat) check("latency", 64'(cyc + 1 - e.acc), 64'(NSEG));
      end
    end
  end

  // Call just after a rising edge; returns on the edge that accepts the op.
  task automatic send(input logic [W-1:0] ia, input logic [W-1:0] ib,
                      input logic icin, input logic isub,
                      input logic [W-1:0] esum, input logic ecout, input logic eovf,
                      input bit lat, input bit push);
    bit done;
    done = 0;
    #1;
    a = ia; b = ib; cin = icin; sub = isub; in_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        done = 1;
        if (push) exp_q.push_back('{sum: esum, cout: ecout, ovf: eovf, acc: cyc + 1, lat: lat});
      end
      @(posedge clk);
    end
    if (!done) check("send_timeout", 64'(0), 64'(1));
  endtask

  task automatic drain();
    #1 in_valid = 1'b0;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
    check("drain", 64'(exp_q.size()), 64'(0));
  endtask

  // --------------------------------------------------------------------------
  // Parameter sweep: random traffic against a flat reference adder
  // --------------------------------------------------------------------------
  localparam int SW_W [3] = '{8, 8, 32};
  localparam int SW_S [3] = '{8, 2, 4};

  genvar s;
  generate
    for (s = 0; s < 3; s++) begin : g_sweep
      localparam int SWW = SW_W[s];
      localparam int SWS = SW_S[s];
      localparam int NS  = SWW / SWS;

      logic           sv_in_valid, sv_in_ready, sv_cin, sv_sub;
      logic           sv_out_valid, sv_out_ready, sv_cout, sv_ovf;
      logic [SWW-1:0] sv_a, sv_b, sv_sum;
      logic [SWW+1:0] sq[$];
      int             acc_q[$];
      bit             lat_q[$];
      bit             done = 0;

      pipelined_segmented_adder #(.WIDTH(SWW), .SEG_WIDTH(SWS)) u_dut (
        .clk(clk), .rst_n(rst_sw_n),
        .in_valid(sv_in_valid), .in_ready(sv_in_ready),
        .a(sv_a), .b(sv_b), .cin(sv_cin), .sub(sv_sub),
        .out_valid(sv_out_valid), .out_ready(sv_out_ready),
        .sum(sv_sum), .cout(sv_cout), .ovf(sv_ovf)
      );

      // {ovf, cout, sum}; overflow = operands agree in sign, result does not.
      function automatic logic [SWW+1:0] model(input logic [SWW-1:0] x, input logic [SWW-1:0] y,
                                               input logic ci, input logic sb);
        logic [SWW:0]   t;
        logic [SWW-1:0] be;
        be = sb ? ~y : y;
        t  = {1'b0, x} + {1'b0, be} + {{SWW{1'b0}}, (sb ? 1'b1 : ci)};
        return {(x[SWW-1] == be[SWW-1]) && (t[SWW-1] != x[SWW-1]), t[SWW], t[SWW-1:0]};
      endfunction

      always @(negedge clk) begin
        if (rst_sw_n && sv_out_valid && sv_out_ready) begin
          if (sq.size() == 0) begin
            check($sformatf("sweep%0d_unexpected_output", s), 64'(sv_out_valid), 64'(0));
          end else begin
            logic [SWW+1:0] e;
            int  ac;
            bit  lt;
            e  = sq.pop_front();
            ac = acc_q.pop_front();
            lt = lat_q.pop_front();
            check($sformatf("sweep%0d_result", s), 64'({sv_ovf, sv_cout, sv_sum}), 64'(e));
            if (lt) check($sformatf("sweep%0d_latency", s), 64'(cyc + 1 - ac), 64'(NS));
          end
        end
      end

      initial begin
        logic [31:0] ra, rb, rc;
        bit pend;
        int sent;
        sv_in_valid = 1'b0; sv_a = '0; sv_b = '0; sv_cin = 1'b0; sv_sub = 1'b0;
        sv_out_ready = 1'b1;
        pend = 0;
        sent = 0;
        wait (rst_sw_n === 1'b1);
        @(posedge clk);
        // Lone op into an empty pipe to measure latency
        #1;
        ra = $urandom(); rb = $urandom();
        sv_a = ra[SWW-1:0]; sv_b = rb[SWW-1:0]; sv_cin = 1'b1; sv_sub = 1'b0; sv_in_valid = 1'b1;
        @(negedge clk);
        check($sformatf("sweep%0d_in_ready_idle", s), 64'(sv_in_ready), 64'(1));
        if (sv_in_ready) begin
          sq.push_back(model(sv_a, sv_b, sv_cin, sv_sub));
          acc_q.push_back(cyc + 1);
          lat_q.push_back(1'b1);
        end
        @(posedge clk);
        #1 sv_in_valid = 1'b0;
        for (int i = 0; i < 30 && sq.size() != 0; i++) @(posedge clk);
        for (int cy = 0; cy < 20000 && (sent < 1000 || sq.size() != 0); cy++) begin
          @(posedge clk);
          #1;
          rc = $urandom();
          sv_out_ready = (rc[1:0] != 2'b00);
          if (!pend) begin
            if (sent < 1000 && rc[3:2] != 2'b00) begin
              ra = $urandom(); rb = $urandom();
              sv_a = ra[SWW-1:0]; sv_b = rb[SWW-1:0];
              sv_cin = rc[4]; sv_sub = rc[5];
              sv_in_valid = 1'b1;
            end else begin
              sv_in_valid = 1'b0;
            end
          end
          @(negedge clk);
          if (sv_in_valid && sv_in_ready) begin
            sq.push_back(model(sv_a, sv_b, sv_cin, sv_sub));
            acc_q.push_back(cyc + 1);
            lat_q.push_back(1'b0);
            sent++;
            pend = 0;
          end else begin
            pend = sv_in_valid;
          end
        end
        #1 sv_in_valid = 1'b0;
        check($sformatf("sweep%0d_ops_sent", s), 64'(sent), 64'(1000));
        check($sformatf("sweep%0d_queue_empty", s), 64'(sq.size()), 64'(0));
        done = 1;
      end
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Main directed sequence
  // --------------------------------------------------------------------------
  initial begin
    int stale;
    bit all_done;
    rst_n = 1'b0; rst_sw_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    out_ready = 1'b1;

    #12;
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_sum", 64'(sum), 64'(0));
    check("reset_cout", 64'(cout), 64'(0));
    check("reset_ovf", 64'(ovf), 64'(0));
    check("reset_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #2 rst_n = 1'b1; rst_sw_n = 1'b1;
    @(posedge clk);

    // Directed single ops, each into an empty pipe (latency checked)
    send(16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0, 1, 1); drain();
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1, 1); drain();
    send(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1, 1); drain();
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1, 1); drain();
    send(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1, 1); drain();
    send(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1, 1); drain();
    send(16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1, 1); drain();
    send(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1, 1); drain();

    // Streaming: 10 back-to-back ops, out_ready low in periods 6..8
    @(posedge clk);
    fork
      begin
        send(16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, 0, 1);
        send(16'h00F0, 16'h0010, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 0, 1);
        send(16'h0FFF, 16'h0001, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0, 0, 1);
        send(16'h0010, 16'h0001, 1'b0, 1'b1, 16'h000F, 1'b1, 1'b0, 0, 1);
        send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 0, 1);
        send(16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 0, 1);
        send(16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 0, 1);
        send(16'hABCD, 16'h1111, 1'b0, 1'b0, 16'hBCDE, 1'b0, 1'b0, 0, 1);
        send(16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 0, 1);
        send(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 0, 1);
        #1 in_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 18; i++) begin
          #1 out_ready = !(i >= 6 && i <= 8);
          @(negedge clk);
          check($sformatf("stream_in_ready_p%0d", i), 64'(in_ready), 64'(!(i >= 6 && i <= 8)));
          check($sformatf("stream_out_valid_p%0d", i), 64'(out_valid), 64'(i >= 4 && i <= 16));
          if (i >= 6 && i <= 8)
            check($sformatf("stall_hold_p%0d", i), 64'({ovf, cout, sum}), 64'({1'b0, 1'b0, 16'h1001}));
          @(posedge clk);
        end
      end
    join
    drain();

    // Reset in flight: three ops discarded, outputs cleared at once
    send(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 0, 0);
    send(16'h0101, 16'h0202, 1'b0, 1'b0, 16'h0303, 1'b0, 1'b0, 0, 0);
    send(16'h7000, 16'h7000, 1'b0, 1'b0, 16'hE000, 1'b0, 1'b1, 0, 0);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("prereset_out_valid", 64'(out_valid), 64'(1));
    check("prereset_sum", 64'(sum), 64'(16'h3333));
    #1 rst_n = 1'b0;
    #1;
    check("midreset_out_valid", 64'(out_valid), 64'(0));
    check("midreset_sum", 64'(sum), 64'(0));
    check("midreset_cout", 64'(cout), 64'(0));
    check("midreset_ovf", 64'(ovf), 64'(0));
    check("midreset_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #2 rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("postreset_stale_outputs", 64'(stale), 64'(0));
    @(posedge clk);
    send(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1, 1);
    drain();

    // Wait for the width sweep to finish
    all_done = 0;
    for (int i = 0; i < 30000 && !all_done; i++) begin
      @(posedge clk);
      all_done = g_sweep[0].done && g_sweep[1].done && g_sweep[2].done;
    end
    check("sweep_complete", 64'(all_done), 64'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
